// File: rtl/regfile_writeback.sv
// regfile_writeback: MEM/WB write-back into R0-R7/T/SP/IH with ID read ports; REGFILE_WB_BYPASS_EN adds write-through bypass
module regfile_writeback #(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] SP_RESET = 16'hBF00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        writeSpecRegIn,
  input  logic              memtoRegIn,
  input  logic              regWriteIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [2:0]        registerToWriteIdIn,
  input  logic [2:0]        readIdA,
  input  logic [2:0]        readIdB,
  output logic [DATA_W-1:0] readDataA,
  output logic [DATA_W-1:0] readDataB,
  output logic [DATA_W-1:0] tOut,
  output logic [DATA_W-1:0] spOut,
  output logic [DATA_W-1:0] ihOut,
  output logic [DATA_W-1:0] wbDataOut,
  output logic              wbValidOut
);
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] tReg, spReg, ihReg, wbData;
  assign wbData = memtoRegIn ? dataIn : ALUResultIn;
  assign wbDataOut = wbData;
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      tReg <= '0;
      spReg <= SP_RESET;
      ihReg <= '0;
      wbValidOut <= 1'b0;
    end else begin
      wbValidOut <= regWriteIn;
      if (regWriteIn) begin
        if (writeSpecRegIn == 2'b00) regs[registerToWriteIdIn] <= wbData;
        if (writeSpecRegIn == 2'b01) tReg <= wbData;
        if (writeSpecRegIn == 2'b10) spReg <= wbData;
        if (writeSpecRegIn == 2'b11) ihReg <= wbData;
      end
    end
  end
`ifdef REGFILE_WB_BYPASS_EN
  logic wrEn;
  assign wrEn = RST && regWriteIn;
  assign readDataA = (wrEn && writeSpecRegIn == 2'b00 && registerToWriteIdIn == readIdA) ? wbData : regs[readIdA];
  assign readDataB = (wrEn && writeSpecRegIn == 2'b00 && registerToWriteIdIn == readIdB) ? wbData : regs[readIdB];
  assign tOut = (wrEn && writeSpecRegIn == 2'b01) ? wbData : tReg;
  assign spOut = (wrEn && writeSpecRegIn == 2'b10) ? wbData : spReg;
  assign ihOut = (wrEn && writeSpecRegIn == 2'b11) ? wbData : ihReg;
`else
  assign readDataA = regs[readIdA];
  assign readDataB = regs[readIdB];
  assign tOut = tReg;
  assign spOut = spReg;
  assign ihOut = ihReg;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed stimulus, per-cycle model comparison plus hand-computed checks
module tb_regfile_writeback;
  logic CLK = 1'b0, RST = 1'b0;
  logic [1:0] writeSpecRegIn = '0;
  logic memtoRegIn = 1'b0, regWriteIn = 1'b0;
  logic [15:0] dataIn = '0, ALUResultIn = '0;
  logic [2:0] registerToWriteIdIn = '0, readIdA = '0, readIdB = '0;
  logic [15:0] readDataA, readDataB, tOut, spOut, ihOut, wbDataOut;
  logic wbValidOut;
  int total = 0, bad = 0;
  logic go = 1'b0;
  logic [15:0] mR [8];
  logic [15:0] mT, mSp, mIh;
  logic mValid;

  regfile_writeback dut (
    .CLK(CLK), .RST(RST), .writeSpecRegIn(writeSpecRegIn), .memtoRegIn(memtoRegIn),
    .regWriteIn(regWriteIn), .dataIn(dataIn), .ALUResultIn(ALUResultIn),
    .registerToWriteIdIn(registerToWriteIdIn), .readIdA(readIdA), .readIdB(readIdB),
    .readDataA(readDataA), .readDataB(readDataB), .tOut(tOut), .spOut(spOut),
    .ihOut(ihOut), .wbDataOut(wbDataOut), .wbValidOut(wbValidOut)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] wbExp();
    return memtoRegIn ? dataIn : ALUResultIn;
  endfunction

  function automatic logic [15:0] expRd(input logic [2:0] id);
`ifdef REGFILE_WB_BYPASS_EN
    if (RST && regWriteIn && writeSpecRegIn == 2'd0 && registerToWriteIdIn == id) return wbExp();
`endif
    return RST ? mR[id] : 16'h0;
  endfunction

  function automatic logic [15:0] expSpec(input logic [1:0] sel, input logic [15:0] stored);
`ifdef REGFILE_WB_BYPASS_EN
    if (RST && regWriteIn && writeSpecRegIn == sel) return wbExp();
`endif
    if (!RST) return (sel == 2'd2) ? 16'hBF00 : 16'h0;
    return stored;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 8; i++) mR[i] <= 16'h0;
      mT <= 16'h0; mSp <= 16'hBF00; mIh <= 16'h0; mValid <= 1'b0;
    end else begin
      mValid <= regWriteIn;
      if (regWriteIn) begin
        if (writeSpecRegIn == 2'd0) mR[registerToWriteIdIn] <= wbExp();
        else if (writeSpecRegIn == 2'd1) mT <= wbExp();
        else if (writeSpecRegIn == 2'd2) mSp <= wbExp();
        else mIh <= wbExp();
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) if (go) begin
    check("cyc readDataA", readDataA, expRd(readIdA));
    check("cyc readDataB", readDataB, expRd(readIdB));
    check("cyc tOut", tOut, expSpec(2'd1, mT));
    check("cyc spOut", spOut, expSpec(2'd2, mSp));
    check("cyc ihOut", ihOut, expSpec(2'd3, mIh));
    check("cyc wbDataOut", wbDataOut, wbExp());
    check("cyc wbValidOut", {15'h0, wbValidOut}, {15'h0, RST && mValid});
  end

  task automatic drive(input logic rw, input logic [1:0] sp, input logic m2r, input logic [15:0] d,
                       input logic [15:0] alu, input logic [2:0] wid, input logic [2:0] ra, input logic [2:0] rb);
    regWriteIn = rw; writeSpecRegIn = sp; memtoRegIn = m2r; dataIn = d;
    ALUResultIn = alu; registerToWriteIdIn = wid; readIdA = ra; readIdB = rb;
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #2;
    go = 1'b1;
    RST = 1'b1;
    step();
    check("rst R5", readDataA, 16'h0);
    check("rst SP", spOut, 16'hBF00);
    check("rst T", tOut, 16'h0);
    drive(1, 2'd0, 0, 16'h0, 16'h1234, 3'd5, 3'd5, 3'd0);
    step();
    check("alu R5", readDataA, 16'h1234);
    check("alu model R5", mR[5], 16'h1234);
    check("alu valid", {15'h0, wbValidOut}, 16'h1);
    drive(0, 2'd0, 0, 16'h0, 16'h0, 3'd5, 3'd5, 3'd0);
    step();
    check("alu valid drop", {15'h0, wbValidOut}, 16'h0);
    drive(1, 2'd1, 1, 16'hA5A5, 16'h1111, 3'd5, 3'd5, 3'd0);
    step();
    drive(1, 2'd2, 1, 16'h0001, 16'h2222, 3'd5, 3'd5, 3'd0);
    step();
    drive(1, 2'd3, 1, 16'h7FFF, 16'h3333, 3'd5, 3'd5, 3'd0);
    step();
    drive(0, 2'd0, 0, 16'h0, 16'h0, 3'd5, 3'd5, 3'd0);
    check("spec T", tOut, 16'hA5A5);
    check("spec SP", spOut, 16'h0001);
    check("spec IH", ihOut, 16'h7FFF);
    check("spec R5 kept", readDataA, 16'h1234);
    check("spec valid b2b", {15'h0, wbValidOut}, 16'h1);
    drive(0, 2'd0, 0, 16'h0, 16'hFFFF, 3'd2, 3'd2, 3'd2);
    #1;
    check("dis wbData", wbDataOut, 16'hFFFF);
    step();
    check("dis R2", readDataA, 16'h0);
    check("dis valid", {15'h0, wbValidOut}, 16'h0);
    drive(1, 2'd0, 1, 16'h00FF, 16'h0, 3'd0, 3'd0, 3'd5);
    step();
    check("R0 write", readDataA, 16'h00FF);
    drive(1, 2'd0, 0, 16'h0, 16'hBEEF, 3'd3, 3'd3, 3'd3);
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    check("byp A same", readDataA, 16'hBEEF);
    check("byp B same", readDataB, 16'hBEEF);
`else
    check("nobyp A same", readDataA, 16'h0);
    check("nobyp B same", readDataB, 16'h0);
`endif
    step();
    check("byp A next", readDataA, 16'hBEEF);
    check("byp B next", readDataB, 16'hBEEF);
    drive(1, 2'd0, 0, 16'h0, 16'h5555, 3'd7, 3'd7, 3'd3);
    RST = 1'b0;
    #1;
    check("midrst valid", {15'h0, wbValidOut}, 16'h0);
    check("midrst SP", spOut, 16'hBF00);
    check("midrst T", tOut, 16'h0);
    check("midrst R3", readDataB, 16'h0);
    repeat (3) @(posedge CLK);
    #2;
    regWriteIn = 1'b0;
    RST = 1'b1;
    step();
    check("midrst R7", readDataA, 16'h0);
    check("midrst IH", ihOut, 16'h0);
    step();
    go = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-back end of the MEM/WB pipeline interface for the 16-bit pipelined CPU.
- Consumes the MEM/WB register outputs and selects the write-back value (memory data or ALU result).
- Commits that value to 8 general-purpose registers (R0-R7) or to one of three special registers (T, SP, IH).
- Provides the combinational read ports used by the ID stage, with optional same-cycle write-to-read bypass.

Parameters:
- DATA_W, 16, register and datapath width.
- SP_RESET, 16'hBF00, reset value of the SP special register.

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-low reset.
- writeSpecRegIn  in  2  write-back destination: 00 general register, 01 T, 10 SP, 11 IH.
- memtoRegIn  in  1  1 = write back dataIn; 0 = write back ALUResultIn.
- regWriteIn  in  1  write enable for the current write-back.
- dataIn  in  16  memory read data from MEM/WB.
- ALUResultIn  in  16  ALU result from MEM/WB.
- registerToWriteIdIn  in  3  general-register index; used only when writeSpecRegIn = 00.
- readIdA  in  3  ID-stage read port A index.
- readIdB  in  3  ID-stage read port B index.
- readDataA  out  16  contents of R[readIdA].
- readDataB  out  16  contents of R[readIdB].
- tOut  out  16  T register.
- spOut  out  16  SP register.
- ihOut  out  16  IH register.
- wbDataOut  out  16  currently selected write-back value (combinational; for forwarding units).
- wbValidOut  out  1  registered; 1 for one cycle after each committed write.

Behaviour:
- Reset (RST = 0, asynchronous; takes effect immediately, independent of CLK):
  - R0-R7, T, IH, wbValidOut go to 0.
  - SP goes to SP_RESET.
  - Reset asserted mid-write aborts that write; no partial update.
  - While RST = 0: readDataA/B, tOut and ihOut read 0; spOut reads SP_RESET.
- Write-back value (combinational): wbData = memtoRegIn ? dataIn : ALUResultIn. Always drives wbDataOut, regardless of regWriteIn.
- Commit on rising CLK edge when RST = 1 and regWriteIn = 1:
  - writeSpecRegIn = 00: R[registerToWriteIdIn] <= wbData.
  - writeSpecRegIn = 01: T <= wbData.
  - writeSpecRegIn = 10: SP <= wbData.
  - writeSpecRegIn = 11: IH <= wbData.
  - Exactly one register is written per cycle. Write latency is 1 cycle.
- When regWriteIn = 0: no state change; writeSpecRegIn and registerToWriteIdIn are ignored.
- wbValidOut <= regWriteIn at every edge. After a commit it stays high for one cycle; it stays high across back-to-back commits.
- R0 is an ordinary writable register; there is no hard-wired zero.
- Reads are combinational from the register array.
  - readIdA = readIdB is legal; both ports return the same value.
  - Without bypass, a write becomes visible on the read ports one cycle after the commit edge.
- Special-register writes never disturb R0-R7, even when registerToWriteIdIn matches a read index.
- No overflow or wrap handling: values are stored verbatim at 16 bits.

Optional Feature:
- Macro name: REGFILE_WB_BYPASS_EN.
- When defined (write-through bypass):
  - If regWriteIn = 1, writeSpecRegIn = 00 and registerToWriteIdIn = readIdA, then readDataA = wbData in the same cycle. Same rule for port B.
  - If regWriteIn = 1 and writeSpecRegIn selects T, SP or IH, the matching tOut, spOut or ihOut shows wbData in the same cycle.
  - Bypass is suppressed while RST = 0.
- When not defined: all reads return the stored register values only. The ID stage must stall one extra cycle on a WB→ID hazard.

Test Plan:
- Reset: pulse RST low for 3 cycles mid-stream → R0-R7, T and IH read 0; spOut = 16'hBF00; wbValidOut = 0 immediately, without waiting for a clock edge.
- General write, ALU path: regWriteIn = 1, writeSpecRegIn = 00, memtoRegIn = 0, ALUResultIn = 16'h1234, registerToWriteIdIn = 5; set readIdA = 5 → readDataA = 16'h1234 after the edge; wbValidOut = 1 for exactly that cycle.
- Memory path and special registers: memtoRegIn = 1 with dataIn = 16'hA5A5, then 16'h0001, 16'h7FFF on writeSpecRegIn = 01, 10, 11 in consecutive cycles → T = A5A5, SP = 0001, IH = 7FFF; R0-R7 unchanged.
- Write disabled: regWriteIn = 0, registerToWriteIdIn = 2, ALUResultIn = 16'hFFFF → R2 keeps its prior value (16'h0000); wbValidOut = 0; wbDataOut = 16'hFFFF.
- Bypass with REGFILE_WB_BYPASS_EN defined: write R3 = 16'hBEEF while readIdA = readIdB = 3 → both ports show 16'hBEEF in the same cycle.
- Bypass without REGFILE_WB_BYPASS_EN: same stimulus → both ports show the old value that cycle and 16'hBEEF the next cycle.
- Reset mid-write: assert RST low in the same cycle a write of 16'h5555 to R7 is presented → R7 = 0 after RST is released.
